bus_cycle_ctrl: RTL
===================

Name: bus_cycle_ctrl

Overview:
- Parametrised 8085-style machine-cycle sequencer driving the external bus control pins (ALE, RDn, WRn, IOMn, S1, S0) and the multiplexed AD bus.
- Sequences the T-states from a single request interface.
- Sits between the CPU control unit (which issues cycle requests) and the pad ring.
- Adds READY wait states with timeout, configurable opcode-fetch length, HOLD/HLDA arbitration and back-to-back cycles.

Parameters:
- ADDR_W, 16, address width (16..24); a_hi carries addr[ADDR_W-1:8].
- DATA_W, 8, data/AD width.
- FETCH_T, 4, opcode-fetch T-states (4 or 6; any other value is illegal and fails an elaboration assertion).
- WAIT_LIMIT, 0, maximum TW states per cycle before forced completion; 0 means unlimited.

Ports:
- clk  in  1  system clock; everything updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  1  cycle request; accepted only while ready_for_req=1.
- cyc  in  3  cycle type (cycle_t).
- addr  in  ADDR_W  cycle address.
- wdata  in  DATA_W  write data.
- ready_for_req  out  1  high in IDLE, and in the last T-state when hold=0.
- rdata  out  DATA_W  captured read data; holds its value until the next read completes.
- done  out  1  one-cycle pulse in the last T-state.
- err  out  1  pulses with done if the cycle ended on wait timeout.
- ready  in  1  external READY.
- hold  in  1  external HOLD.
- hlda  out  1  hold acknowledge.
- ALE  out  1  address latch enable.
- RDn  out  1  read strobe, active low.
- WRn  out  1  write strobe, active low.
- IOMn  out  1  1 for I/O or INTA cycles, 0 for memory cycles.
- S1  out  1  status bit 1.
- S0  out  1  status bit 0.
- ad_out  out  DATA_W  AD bus drive value.
- ad_oe  out  1  AD bus drive enable.
- ad_in  in  DATA_W  AD bus sampled value.
- a_hi  out  ADDR_W-8  high address bits.

Behaviour:
- Reset (async, rst=0):
  - State IDLE.
  - ALE=0, RDn=1, WRn=1, IOMn=0, S1=0, S0=0.
  - ad_oe=0, ad_out=0, a_hi=0, rdata=0, done=0, err=0, hlda=0, ready_for_req=1.
  - All latched request fields are cleared.
  - Reset mid-cycle aborts the cycle immediately; no done pulse is produced.
- States: IDLE, T1, T2, TW, T3, T4, T5, T6, HOLD.
- Acceptance:
  - req=1 and ready_for_req=1 at a rising edge latches cyc, addr and wdata; the next state is T1.
  - Latency from request to ALE is one cycle.
- Status (IOMn,S1,S0), held from T1 to the last T-state:
  - FETCH 0,1,1
  - MEMRD 0,1,0
  - MEMWR 0,0,1
  - IORD 1,1,0
  - IOWR 1,0,1
  - INTA 1,1,1
- In IDLE and HOLD, status is 0,0,0 and RDn/WRn are 1.
- T1:
  - ALE=1, ad_oe=1, ad_out=addr[7:0].
  - a_hi=addr[ADDR_W-1:8] for memory cycles.
  - For IORD/IOWR, a_hi = port number (addr[7:0]) in its low 8 bits, upper bits 0.
  - a_hi holds through the last T-state.
- Read types (FETCH, MEMRD, IORD, INTA):
  - RDn=0 in T2, TW and T3.
  - ad_oe=0 from T2 onward.
  - rdata <= ad_in at the end of T3.
- Write types (MEMWR, IOWR):
  - WRn=0 in T2, TW and T3.
  - ad_oe=1 and ad_out=wdata in T2, TW and T3.
- Wait states:
  - READY is sampled at the end of T2 and of each TW.
  - ready=0 goes to (or stays in) TW; ready=1 goes to T3.
  - The wait counter resets in T1.
  - If WAIT_LIMIT>0 and the count reaches WAIT_LIMIT, the next state is T3 regardless of READY, and err is flagged.
- Last T-state:
  - T3 for non-fetch cycles.
  - For FETCH: T4, or T6 when FETCH_T=6 (T3→T4→T5→T6). Strobes are inactive and ad_oe=0 in T4..T6.
  - done=1 (and err if flagged) in the last T-state only.
- Next state after the last T-state:
  - hold=1: HOLD.
  - Otherwise req=1: T1 back-to-back, with no idle cycle.
  - Otherwise: IDLE.
- HOLD:
  - Entered from IDLE when hold=1; hold has priority over a simultaneous req.
  - hold is never honoured mid-cycle.
  - In HOLD: hlda=1, ad_oe=0, RDn=WRn=1, ready_for_req=0.
  - hold=0 returns to IDLE the next cycle, with hlda=0.
- Outputs are decoded from registered state and latched fields, so they are glitch-free with respect to the request inputs.

Decomposition:
- bus_pkg holds:
  - cycle_t enum: FETCH, MEMRD, MEMWR, IORD, IOWR, INTA.
  - tstate_t enum.
  - Function status_of(cycle_t) returning {IOMn,S1,S0}.
  - Functions is_read/is_write.
- No sub-module; the wait counter is a plain counter inside the FSM module.

Test Plan:
- MEMRD, addr=16'h1234, ad_in=8'h43, ready=1 → T1: ALE=1, ad_out=8'h34, a_hi=8'h12, status 0,1,0; RDn=0 in T2–T3; done in T3; rdata=8'h43. Cycle is 3 clk long.
- FETCH with FETCH_T=4, then again with FETCH_T=6 → done in T4 and T6 respectively; status 0,1,1; rdata captured at end of T3.
- IOWR, addr=16'h00A5, wdata=8'h5C, ready low for 2 cycles → a_hi=8'hA5, IOMn=1, two TW states, WRn low 4 cycles, ad_out=8'h5C in T2–T3, err=0.
- WAIT_LIMIT=3, ready held 0 → exactly 3 TW states then T3; done=1 and err=1 in the same cycle.
- Back-to-back MEMWR then MEMRD with req held → second ALE in the cycle after the first done. Then hold=1 together with a req while IDLE → HOLD entered, hlda=1, req ignored until hold=0.
- rst=0 asserted in the TW state of a MEMRD → all outputs return to reset values immediately, no done pulse, rdata=0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and decode helpers for the 8085-style bus cycle sequencer.
// Cycle types, T-state encoding and per-cycle status/direction lookups.
package bus_pkg;

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        MEMRD = 3'd1,
        MEMWR = 3'd2,
        IORD  = 3'd3,
        IOWR  = 3'd4,
        INTA  = 3'd5
    } cycle_t;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T1   = 4'd1,
        S_T2   = 4'd2,
        S_TW   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HOLD = 4'd8
    } tstate_t;

    // {IOMn, S1, S0} for each cycle type
    function automatic logic [2:0] status_of(cycle_t c);
        logic [2:0] s;
        s = 3'b000;
        case (c)
            FETCH:   s = 3'b011;
            MEMRD:   s = 3'b010;
            MEMWR:   s = 3'b001;
            IORD:    s = 3'b110;
            IOWR:    s = 3'b101;
            INTA:    s = 3'b111;
            default: s = 3'b000;
        endcase
        return s;
    endfunction

    function automatic logic is_read(cycle_t c);
        return (c == FETCH) || (c == MEMRD) || (c == IORD) || (c == INTA);
    endfunction

    function automatic logic is_write(cycle_t c);
        return (c == MEMWR) || (c == IOWR);
    endfunction

    // I/O port cycles put the 8-bit port number on the high address pins
    function automatic logic is_io(cycle_t c);
        return (c == IORD) || (c == IOWR);
    endfunction

endpackage

// File: rtl/bus_cycle_ctrl.sv
// Machine-cycle sequencer: T-state FSM driving ALE/RDn/WRn/status and AD.
// Handles READY wait states with optional timeout and HOLD/HLDA.
module bus_cycle_ctrl
    import bus_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int FETCH_T    = 4,
    parameter int WAIT_LIMIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  cycle_t            cyc,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready_for_req,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              err,
    input  logic              ready,
    input  logic              hold,
    output logic              hlda,
    output logic              ALE,
    output logic              RDn,
    output logic              WRn,
    output logic              IOMn,
    output logic              S1,
    output logic              S0,
    output logic [DATA_W-1:0] ad_out,
    output logic              ad_oe,
    input  logic [DATA_W-1:0] ad_in,
    output logic [ADDR_W-9:0] a_hi
);

    localparam int AHW = ADDR_W - 8;
    localparam int CW  = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [CW-1:0] WLIM = CW'(WAIT_LIMIT);

    if (FETCH_T != 4 && FETCH_T != 6) begin : g_bad_fetch_t
        $error("bus_cycle_ctrl: FETCH_T must be 4 or 6");
    end
    if (ADDR_W < 16 || ADDR_W > 24) begin : g_bad_addr_w
        $error("bus_cycle_ctrl: ADDR_W must be 16..24");
    end

    tstate_t           state_q, state_d;
    cycle_t            cyc_q, cyc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CW-1:0]     wcnt_q, wcnt_d;
    logic              terr_q, terr_d;

    logic in_cyc;
    logic strb;
    logic last_c;
    logic go;

    // Output decode from registered state and latched request fields
    always_comb begin
        in_cyc = (state_q != S_IDLE) && (state_q != S_HOLD);
        strb   = (state_q == S_T2) || (state_q == S_TW) || (state_q == S_T3);
        last_c = ((state_q == S_T3) && (cyc_q != FETCH))
              || ((state_q == S_T4) && (FETCH_T == 4))
              || (state_q == S_T6);

        ALE            = (state_q == S_T1);
        {IOMn, S1, S0} = in_cyc ? status_of(cyc_q) : 3'b000;
        RDn            = ~(strb & is_read(cyc_q));
        WRn            = ~(strb & is_write(cyc_q));
        ad_oe          = (state_q == S_T1) | (strb & is_write(cyc_q));

        ad_out = '0;
        if (state_q == S_T1) begin
            ad_out = DATA_W'(addr_q[7:0]);
        end else if (strb && is_write(cyc_q)) begin
            ad_out = wdata_q;
        end

        a_hi = '0;
        if (in_cyc) begin
            a_hi = is_io(cyc_q) ? AHW'(addr_q[7:0]) : addr_q[ADDR_W-1:8];
        end

        done          = last_c;
        err           = last_c & terr_q;
        hlda          = (state_q == S_HOLD);
        ready_for_req = (state_q == S_IDLE) | (last_c & ~hold);
        rdata         = rdata_q;
    end

    // Next-state, request latching, wait counting and read capture
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        wcnt_d  = wcnt_q;
        terr_d  = terr_q;
        go      = req & ready_for_req & ~hold;

        if (go) begin
            cyc_d   = cyc;
            addr_d  = addr;
            wdata_d = wdata;
        end

        unique case (state_q)
            S_IDLE: begin
                if (hold)     state_d = S_HOLD;
                else if (req) state_d = S_T1;
            end
            S_T1: begin
                state_d = S_T2;
                wcnt_d  = '0;
                terr_d  = 1'b0;
            end
            S_T2, S_TW: begin
                if (WAIT_LIMIT > 0 && wcnt_q == WLIM) begin
                    state_d = S_T3;
                    terr_d  = ~ready;
                end else if (ready) begin
                    state_d = S_T3;
                end else begin
                    state_d = S_TW;
                    wcnt_d  = wcnt_q + CW'(1);
                end
            end
            S_T3: begin
                if (is_read(cyc_q)) rdata_d = ad_in;
                state_d = (cyc_q == FETCH) ? S_T4 : S_IDLE;
            end
            S_T4:    state_d = (FETCH_T == 6) ? S_T5 : S_IDLE;
            S_T5:    state_d = S_T6;
            S_T6:    state_d = S_IDLE;
            S_HOLD:  if (!hold) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Hold wins at a cycle boundary; otherwise chain straight into T1
        if (last_c) begin
            if (hold)     state_d = S_HOLD;
            else if (req) state_d = S_T1;
            else          state_d = S_IDLE;
        end
    end

    // State and latched-field registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cyc_q   <= FETCH;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wcnt_q  <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wcnt_q  <= wcnt_d;
            terr_q  <= terr_d;
        end
    end

endmodule
